// File: rtl/sha256_block_sequencer.sv
// Purpose: assemble 32-bit message words into 512-bit blocks and issue
// init/next/final commands to the SHA-256 padding/core stage.
// The last word is MSB-masked to its valid bit count, and final_len carries the
// number of message bits in the final block.
//
// Ports:
//   clk, reset_n        clock; asynchronous active-low reset
//   start               begin a new message (sampled in IDLE only)
//   word_valid/ready    word handshake (ready only while collecting)
//   word_data/last/bits message word, end-of-message flag, valid MSBs in last word
//   core_ready          downstream padding/core idle
//   init_out/next_out/final_out  single-cycle command pulses
//   final_len           bits in final block (0..512), valid with final_out
//   block_out           assembled block, word 0 in bits 511:480
//   busy, done          activity flag and end-of-message pulse
//   blocks_issued       next+final pulse count since init
//
// Build option: define SHA256_SEQ_BLOCK_CTR_EN to enable the blocks_issued
// counter. When it is undefined, blocks_issued is tied to zero.
module sha256_block_sequencer (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         word_valid,
  output logic         word_ready,
  input  logic [31:0]  word_data,
  input  logic         word_last,
  input  logic [5:0]   word_bits,
  input  logic         core_ready,
  output logic         init_out,
  output logic         next_out,
  output logic         final_out,
  // 10 bits so that a completely full 512-bit final block is representable
  output logic [9:0]   final_len,
  output logic [511:0] block_out,
  output logic         busy,
  output logic         done,
  output logic [31:0]  blocks_issued
);

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BLOCK_W   = 512;
  localparam int unsigned WORDS     = BLOCK_W / WORD_W;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned LEN_W     = 10;
  localparam int unsigned BITS_W    = 6;
  localparam int unsigned PAD_LIMIT = 448;

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_ISSUE, S_WAIT, S_FLUSH, S_DONE
  } state_t;

  state_t             state_q, state_n;
  logic [IDX_W-1:0]   idx_q;
  logic               is_final_q;
  logic               guard_q;

  logic               xfer_c;
  logic               exit_c;
  logic [BITS_W-1:0]  bits_c;
  logic [WORD_W-1:0]  mask_c;
  logic [WORD_W-1:0]  store_c;
  logic [LEN_W-1:0]   len_c;

  logic               init_c, next_c, final_c, done_c, busy_c, ready_c, guard_c;

  assign xfer_c = word_valid & word_ready;
  // The guard ignores core_ready for the first cycle in WAIT/FLUSH, when the core may not yet have dropped it.
  assign exit_c = ~guard_q & core_ready;

  // Clamp the valid-bit count and keep only the valid MSBs of the last word.
  assign bits_c  = (word_bits > BITS_W'(WORD_W)) ? BITS_W'(WORD_W) : word_bits;
  assign mask_c  = (bits_c == '0) ? '0 : (32'hFFFF_FFFF << (BITS_W'(WORD_W) - bits_c));
  assign store_c = word_last ? (word_data & mask_c) : word_data;
  assign len_c   = LEN_W'({idx_q, 5'b00000}) + LEN_W'(bits_c);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:    if (start) state_n = S_COLLECT;
      S_COLLECT: if (xfer_c && (word_last || idx_q == IDX_W'(WORDS - 1))) state_n = S_ISSUE;
      S_ISSUE:   state_n = S_WAIT;
      S_WAIT: begin
        if (exit_c) begin
          if (!is_final_q)                          state_n = S_COLLECT;
          else if (final_len >= LEN_W'(PAD_LIMIT))  state_n = S_FLUSH;
          else                                      state_n = S_DONE;
        end
      end
      S_FLUSH:   if (exit_c) state_n = S_DONE;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered control outputs
  always_comb begin
    init_c  = 1'b0;
    next_c  = 1'b0;
    final_c = 1'b0;
    done_c  = 1'b0;
    busy_c  = 1'b0;
    ready_c = 1'b0;
    guard_c = 1'b0;
    init_c  = (state_q == S_IDLE) && start;
    next_c  = (state_q == S_ISSUE) && !is_final_q;
    final_c = (state_q == S_ISSUE) && is_final_q;
    done_c  = (state_n == S_DONE);
    busy_c  = (state_n != S_IDLE);
    ready_c = (state_n == S_COLLECT);
    guard_c = ((state_n == S_WAIT)  && (state_q != S_WAIT)) ||
              ((state_n == S_FLUSH) && (state_q != S_FLUSH));
  end

  // Registered control outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_out   <= 1'b0;
      next_out   <= 1'b0;
      final_out  <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      word_ready <= 1'b0;
      guard_q    <= 1'b0;
    end else begin
      init_out   <= init_c;
      next_out   <= next_c;
      final_out  <= final_c;
      done       <= done_c;
      busy       <= busy_c;
      word_ready <= ready_c;
      guard_q    <= guard_c;
    end
  end

  // Block buffer, word index, final length
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      block_out  <= '0;
      idx_q      <= '0;
      is_final_q <= 1'b0;
      final_len  <= '0;
    end else if (init_c) begin
      block_out  <= '0;
      idx_q      <= '0;
      is_final_q <= 1'b0;
      final_len  <= '0;
    end else if (state_q == S_COLLECT && xfer_c) begin
      for (int unsigned i = 0; i < WORDS; i++) begin
        if (idx_q == IDX_W'(i)) block_out[BLOCK_W-1-WORD_W*i -: WORD_W] <= store_c;
      end
      if (word_last) begin
        is_final_q <= 1'b1;
        final_len  <= len_c;
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end else if (state_q == S_WAIT && exit_c && !is_final_q) begin
      // Start collecting the next block from a clean buffer.
      block_out <= '0;
      idx_q     <= '0;
    end
  end

`ifdef SHA256_SEQ_BLOCK_CTR_EN
  logic [31:0] blk_cnt_q;

  // Counts next/final commands issued since the last init.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                blk_cnt_q <= '0;
    else if (init_c)             blk_cnt_q <= '0;
    else if (next_c || final_c)  blk_cnt_q <= blk_cnt_q + 32'd1;
  end

  assign blocks_issued = blk_cnt_q;
`else
  assign blocks_issued = '0;
`endif

endmodule
